// File: rtl/ysyx_23060184_rf_wb_ctrl_if.sv
// Write-back controller bus: issue/decode, EXU and LSU
// write-back sources, register-file write port, scoreboard.
interface ysyx_23060184_rf_wb_ctrl_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                     iss_valid;
  logic                     iss_wen;
  logic [ADDR_WIDTH-1:0]    iss_rd;
  logic [ADDR_WIDTH-1:0]    rs1;
  logic [ADDR_WIDTH-1:0]    rs2;
  logic                     hazard;

  logic                     e_valid;
  logic                     e_wen;
  logic [ADDR_WIDTH-1:0]    e_waddr;
  logic [DATA_WIDTH-1:0]    e_wdata;
  logic                     e_ready;

  logic                     l_valid;
  logic                     l_wen;
  logic [ADDR_WIDTH-1:0]    l_waddr;
  logic [DATA_WIDTH-1:0]    l_wdata;
  logic                     l_ready;

  logic                     rf_wvalid;
  logic                     rf_wen;
  logic [ADDR_WIDTH-1:0]    rf_waddr;
  logic [DATA_WIDTH-1:0]    rf_wdata;
  logic [2**ADDR_WIDTH-1:0] pend;

  modport slave (
    input  iss_valid, iss_wen, iss_rd, rs1, rs2,
    input  e_valid, e_wen, e_waddr, e_wdata,
    input  l_valid, l_wen, l_waddr, l_wdata,
    output hazard, e_ready, l_ready,
    output rf_wvalid, rf_wen, rf_waddr, rf_wdata, pend
  );

  modport master (
    output iss_valid, iss_wen, iss_rd, rs1, rs2,
    output e_valid, e_wen, e_waddr, e_wdata,
    output l_valid, l_wen, l_waddr, l_wdata,
    input  hazard, e_ready, l_ready,
    input  rf_wvalid, rf_wen, rf_waddr, rf_wdata, pend
  );
endinterface

// File: rtl/ysyx_23060184_rf_wb_ctrl.sv
// Register-file write-back arbiter (EXU/LSU round-robin)
// with a pending-write scoreboard for decode hazards.
module ysyx_23060184_rf_wb_ctrl #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic clk,
  input  logic reset,
  ysyx_23060184_rf_wb_ctrl_if.slave bus
);
  localparam int NREG = 2**ADDR_WIDTH;

  logic                  prio_q, prio_d;
  logic                  rf_wvalid_q, rf_wvalid_d;
  logic                  rf_wen_q, rf_wen_d;
  logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
  logic [NREG-1:0]       pend_q, pend_d;

  logic                  grant_e, grant_l;
  logic                  src_wen;
  logic [ADDR_WIDTH-1:0] src_waddr;
  logic [DATA_WIDTH-1:0] src_wdata;
  logic                  iss_set;
  logic                  rf_clr;

  // Round-robin grant; prio names the favoured source on a tie
  always_comb begin
    grant_e = 1'b0;
    grant_l = 1'b0;
    if (!reset) begin
      grant_e = bus.e_valid && (!bus.l_valid || !prio_q);
      grant_l = bus.l_valid && (!bus.e_valid || prio_q);
    end
    src_wen   = grant_l ? bus.l_wen   : bus.e_wen;
    src_waddr = grant_l ? bus.l_waddr : bus.e_waddr;
    src_wdata = grant_l ? bus.l_wdata : bus.e_wdata;
  end

  // Next pointer and output-register contents
  always_comb begin
    prio_d      = prio_q;
    rf_wvalid_d = 1'b0;
    rf_wen_d    = 1'b0;
    rf_waddr_d  = rf_waddr_q;
    rf_wdata_d  = rf_wdata_q;
    if (grant_e || grant_l) begin
      prio_d      = grant_e;
      rf_wvalid_d = 1'b1;
      rf_wen_d    = src_wen && (src_waddr != '0);
      rf_waddr_d  = src_waddr;
      rf_wdata_d  = src_wdata;
    end
  end

  // Scoreboard: clear on commit, then set on issue (set wins)
  always_comb begin
    iss_set = bus.iss_valid && bus.iss_wen && (bus.iss_rd != '0);
    rf_clr  = rf_wvalid_q && rf_wen_q;
    pend_d  = pend_q;
    if (rf_clr) pend_d[rf_waddr_q] = 1'b0;
    if (iss_set) pend_d[bus.iss_rd] = 1'b1;
    pend_d[0] = 1'b0;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q      <= 1'b0;
      rf_wvalid_q <= 1'b0;
      rf_wen_q    <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      pend_q      <= '0;
    end else begin
      prio_q      <= prio_d;
      rf_wvalid_q <= rf_wvalid_d;
      rf_wen_q    <= rf_wen_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      pend_q      <= pend_d;
    end
  end

  // Decode stall: RAW on either source, WAW on destination
  always_comb begin
    bus.hazard = ((bus.rs1 != '0) && pend_q[bus.rs1])
              || ((bus.rs2 != '0) && pend_q[bus.rs2])
              || (bus.iss_wen && (bus.iss_rd != '0)
                  && pend_q[bus.iss_rd]);
  end

  assign bus.e_ready   = grant_e;
  assign bus.l_ready   = grant_l;
  assign bus.rf_wvalid = rf_wvalid_q;
  assign bus.rf_wen    = rf_wen_q;
  assign bus.rf_waddr  = rf_waddr_q;
  assign bus.rf_wdata  = rf_wdata_q;
  assign bus.pend      = pend_q;
endmodule

// File: tb/tb_ysyx_23060184_rf_wb_ctrl.sv
// Scoreboard bench for ysyx_23060184_rf_wb_ctrl:
// directed beats queued as expected, monitor checks rf port.
module tb_ysyx_23060184_rf_wb_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ysyx_23060184_rf_wb_ctrl_if #(5, 32) bus();

  ysyx_23060184_rf_wb_ctrl #(
    .ADDR_WIDTH(5),
    .DATA_WIDTH(32)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    logic        w;
  } beat_t;

  beat_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(logic [4:0] a, logic [31:0] d,
                      logic w);
    beat_t b;
    b.a = a; b.d = d; b.w = w;
    exp_q.push_back(b);
  endtask

  task automatic e_beat(logic [4:0] a, logic [31:0] d);
    bus.e_valid = 1'b1; bus.e_wen = 1'b1;
    bus.e_waddr = a;    bus.e_wdata = d;
  endtask

  task automatic l_beat(logic [4:0] a, logic [31:0] d);
    bus.l_valid = 1'b1; bus.l_wen = 1'b1;
    bus.l_waddr = a;    bus.l_wdata = d;
  endtask

  task automatic issue(logic [4:0] rd);
    bus.iss_valid = 1'b1; bus.iss_wen = 1'b1;
    bus.iss_rd = rd;
  endtask

  task automatic no_issue();
    bus.iss_valid = 1'b0; bus.iss_wen = 1'b0;
    bus.iss_rd = '0;
  endtask

  // Monitor: every write-back beat must match the queue head
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && bus.rf_wvalid) begin
        if (exp_q.size() == 0) begin
          chk("beat_unexpected", 1, 0);
        end else begin
          beat_t b;
          b = exp_q.pop_front();
          chk("rf_waddr", bus.rf_waddr, b.a);
          chk("rf_wdata", bus.rf_wdata, b.d);
          chk("rf_wen", bus.rf_wen, b.w);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    no_issue();
    bus.rs1 = '0; bus.rs2 = '0;
    bus.e_valid = 1'b1; bus.e_wen = 1'b1;
    bus.e_waddr = 5'd1; bus.e_wdata = 32'h1;
    bus.l_valid = 1'b1; bus.l_wen = 1'b1;
    bus.l_waddr = 5'd2; bus.l_wdata = 32'h2;

    // Reset held 2 cycles with both valids high
    @(negedge clk);
    chk("rst_e_ready", bus.e_ready, 0);
    chk("rst_l_ready", bus.l_ready, 0);
    cyc();
    @(negedge clk);
    chk("rst_e_ready2", bus.e_ready, 0);
    chk("rst_l_ready2", bus.l_ready, 0);
    cyc();
    reset = 1'b0;
    bus.e_valid = 1'b0; bus.l_valid = 1'b0;
    @(negedge clk);
    chk("rst_wvalid", bus.rf_wvalid, 0);
    chk("rst_wen", bus.rf_wen, 0);
    chk("rst_waddr", bus.rf_waddr, 0);
    chk("rst_wdata", bus.rf_wdata, 0);
    chk("rst_pend", bus.pend, 0);
    chk("rst_hazard", bus.hazard, 0);

    // Single EXU beat
    cyc();
    e_beat(5'd5, 32'hDEADBEEF);
    push(5'd5, 32'hDEADBEEF, 1'b1);
    @(negedge clk);
    chk("single_e_ready", bus.e_ready, 1);
    chk("single_l_ready", bus.l_ready, 0);
    cyc();
    bus.e_valid = 1'b0;
    cyc();

    // Round-robin from reset: E, L, E, L
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    e_beat(5'd1, 32'h11);
    l_beat(5'd2, 32'h22);
    push(5'd1, 32'h11, 1'b1);
    @(negedge clk);
    chk("rr0_e", bus.e_ready, 1);
    chk("rr0_l", bus.l_ready, 0);
    cyc();
    e_beat(5'd3, 32'h33);
    push(5'd2, 32'h22, 1'b1);
    @(negedge clk);
    chk("rr1_e", bus.e_ready, 0);
    chk("rr1_l", bus.l_ready, 1);
    cyc();
    l_beat(5'd4, 32'h44);
    push(5'd3, 32'h33, 1'b1);
    @(negedge clk);
    chk("rr2_e", bus.e_ready, 1);
    chk("rr2_l", bus.l_ready, 0);
    cyc();
    bus.e_valid = 1'b0;
    push(5'd4, 32'h44, 1'b1);
    @(negedge clk);
    chk("rr3_e", bus.e_ready, 0);
    chk("rr3_l", bus.l_ready, 1);
    cyc();
    bus.l_valid = 1'b0;

    // Reset mid-operation clears pend, blocks acceptance
    issue(5'd12);
    cyc();
    no_issue();
    bus.rs1 = 5'd12;
    @(negedge clk);
    chk("mid_pend12", bus.pend, 32'h0000_1000);
    chk("mid_hazard", bus.hazard, 1);
    cyc();
    bus.rs1 = '0;
    reset = 1'b1;
    e_beat(5'd12, 32'hC);
    @(negedge clk);
    chk("mid_e_ready", bus.e_ready, 0);
    cyc();
    reset = 1'b0;
    bus.e_valid = 1'b0;
    @(negedge clk);
    chk("mid_pend", bus.pend, 0);
    chk("mid_wvalid", bus.rf_wvalid, 0);

    // RAW stall on x7 released by LSU write-back
    cyc();
    issue(5'd7);
    cyc();
    no_issue();
    bus.rs1 = 5'd7;
    l_beat(5'd7, 32'h77);
    push(5'd7, 32'h77, 1'b1);
    @(negedge clk);
    chk("raw_hazard0", bus.hazard, 1);
    chk("raw_pend7", bus.pend[7], 1);
    chk("raw_l_ready", bus.l_ready, 1);
    cyc();
    bus.l_valid = 1'b0;
    bus.rs1 = '0;
    bus.iss_wen = 1'b1; bus.iss_rd = 5'd7;
    @(negedge clk);
    chk("waw_hazard", bus.hazard, 1);
    cyc();
    @(negedge clk);
    chk("raw_hazard_drop", bus.hazard, 0);
    chk("raw_pend_clr", bus.pend, 0);
    cyc();
    no_issue();

    // x0 destination and x0 write-back
    issue(5'd0);
    @(negedge clk);
    chk("x0_hazard", bus.hazard, 0);
    cyc();
    no_issue();
    l_beat(5'd0, 32'h1234);
    push(5'd0, 32'h1234, 1'b0);
    @(negedge clk);
    chk("x0_pend", bus.pend, 0);
    cyc();
    bus.l_valid = 1'b0;

    // Set/clear collision on x9: set wins
    issue(5'd9);
    cyc();
    no_issue();
    e_beat(5'd9, 32'h99);
    push(5'd9, 32'h99, 1'b1);
    @(negedge clk);
    chk("col_pend9", bus.pend[9], 1);
    cyc();
    bus.e_valid = 1'b0;
    issue(5'd9);
    cyc();
    no_issue();
    bus.rs2 = 5'd9;
    @(negedge clk);
    chk("col_pend_after", bus.pend, 32'h0000_0200);
    chk("col_hazard", bus.hazard, 1);

    // Issue and unrelated write-back in the same cycle
    cyc();
    bus.rs2 = '0;
    e_beat(5'd3, 32'h3333);
    push(5'd3, 32'h3333, 1'b1);
    issue(5'd20);
    cyc();
    no_issue();
    bus.e_valid = 1'b0;
    cyc();
    @(negedge clk);
    chk("indep_pend", bus.pend, 32'h0010_0200);

    cyc();
    cyc();
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ysyx_23060184_rf_wb_ctrl.md
# ysyx_23060184_rf_wb_ctrl

Write-back controller for the 32-entry register file. It arbitrates the single register-file write port between two write-back sources, EXU (ALU/CSR results) and LSU (load data), using round-robin priority. It also keeps a pending-write scoreboard so the decode stage can stall on RAW/WAW hazards. It sits between the EXU/LSU write-back outputs and the register file's `wen`/`waddr`/`wdata`/`Wvalid` inputs, and alongside decode.

## Interface
- ADDR_WIDTH, 5, register index width
- DATA_WIDTH, 32, register data width

- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- iss_valid  in  1  decode issues an instruction this cycle
- iss_wen  in  1  issued instruction writes a destination register
- iss_rd  in  ADDR_WIDTH  destination index of the issued instruction
- rs1, rs2  in  ADDR_WIDTH  source indices being decoded
- hazard  out  1  combinational stall request to decode
- e_valid, e_wen  in  1  EXU write-back beat valid; beat writes a register
- e_waddr  in  ADDR_WIDTH  EXU destination index
- e_wdata  in  DATA_WIDTH  EXU result
- e_ready  out  1  EXU beat accepted this cycle
- l_valid, l_wen, l_waddr, l_wdata, l_ready  as above, for the LSU
- rf_wvalid  out  1  registered write-back beat to the register file
- rf_wen  out  1  registered write enable
- rf_waddr  out  ADDR_WIDTH  registered write index
- rf_wdata  out  DATA_WIDTH  registered write data
- pend  out  2**ADDR_WIDTH  scoreboard bitmap, for debug/trace

## Operation
- **Arbitration.** A 1-bit priority pointer `prio` selects the favoured source (0 = EXU, 1 = LSU).
  - Only one source valid: that source is granted.
  - Both valid: the source named by `prio` is granted.
  - `e_ready`/`l_ready` equal the grant, are combinational from the valids, and are forced to 0 during `reset`.
  - Sources must not make valid depend on ready.
- **Pointer update.** On any accepted beat, `prio` moves to the source that was not granted. With no grant, `prio` holds.
- **Output register.**
  - On the edge after acceptance: `rf_wvalid` = 1, `rf_wen` = src_wen && src_waddr != 0, and `rf_waddr`/`rf_wdata` take the source values.
  - With no acceptance, `rf_wvalid` and `rf_wen` go to 0, and `rf_waddr`/`rf_wdata` hold.
  - Writes to x0 are forwarded with `rf_wen` = 0.
- **Scoreboard set.** `pend[iss_rd]` is set on the edge where iss_valid && iss_wen && iss_rd != 0.
- **Scoreboard clear.** `pend[rf_waddr]` is cleared on the edge where rf_wvalid && rf_wen. This is the same edge the register file commits the data, so a released reader sees the new value.
- **Set/clear collision.** Same index set and cleared on one edge: set wins, because a new producer is in flight.
- **Hazard equation.** hazard = (rs1 != 0 && pend[rs1]) || (rs2 != 0 && pend[rs2]) || (iss_wen && iss_rd != 0 && pend[iss_rd]).
  - `pend[0]` is always 0.
  - Issuing while hazard = 1 is illegal for decode. The block does not check it and simply sets the bit.
- **Ordering.** In-order per destination: at most one outstanding producer per register, guaranteed by the WAW term.

## Timing
- **Reset values.** `prio` = 0, `pend` = 0, `rf_wvalid` = 0, `rf_wen` = 0, `rf_waddr` = 0, `rf_wdata` = 0. `hazard` = 0, because `pend` = 0.
- **Reset mid-operation.** Reset mid-operation drops any beat held in the output register (no commit). `pend` is cleared. Ready outputs are 0 for the reset cycle.
- **Throughput.** One beat per cycle. A losing source waits at most 1 cycle when the other source is continuously valid.
- **Latency.** Source acceptance at edge N gives `rf_wvalid` high during cycle N..N+1. The register file commits at edge N+1. The `pend` bit clears at edge N+1. `hazard` drops combinationally in the cycle after edge N+1.
- **Same-cycle issue and write-back.** An issue and an unrelated write-back in the same cycle update independent bits.
- **Simultaneous valids.** Simultaneous valids on consecutive cycles alternate grants: E, L, E, L...

## Test plan
- **Reset.** Hold reset 2 cycles with both valids high → e_ready = l_ready = 0; after release all outputs 0, pend = 0.
- **Single source.** EXU only, e_waddr = 5, e_wdata = 0xDEADBEEF, e_wen = 1 → e_ready = 1 that cycle; next cycle rf_wvalid = 1, rf_wen = 1, rf_waddr = 5, rf_wdata = 0xDEADBEEF; prio = 1.
- **Round-robin.** Both sources continuously valid for 4 cycles from reset → grants E, L, E, L; each loser accepted the following cycle.
- **RAW stall.** Issue rd = 7, then decode rs1 = 7 → hazard = 1 until the LSU write-back to x7 commits, then 0 the cycle after rf_wvalid; pend[7] back to 0.
- **x0 handling.** Issue iss_rd = 0 → pend unchanged, hazard stays 0; LSU beat to waddr 0 → rf_wvalid = 1, rf_wen = 0.
- **Collision.** Commit to x9 and issue rd = 9 on the same edge → pend[9] = 1 afterwards; hazard remains asserted for rs2 = 9.
